// File: rtl/clock_counter_pkg.sv
// Shared limits, control-bit positions and BCD helper for the clock counter.
package clock_counter_pkg;

  localparam int unsigned MS_MAX      = 999;
  localparam int unsigned SEC_MAX     = 59;
  localparam int unsigned MIN_MAX     = 59;
  localparam int unsigned HR_MAX      = 23;

  localparam int unsigned MS_DIGITS   = 3;
  localparam int unsigned TIME_DIGITS = 2;
  localparam int unsigned SET_W       = 6;

  localparam int unsigned SET_DIR     = 0;
  localparam int unsigned SET_PAUSE   = 1;
  localparam int unsigned SET_CLR     = 2;
  localparam int unsigned SET_SEC     = 3;
  localparam int unsigned SET_MIN     = 4;
  localparam int unsigned SET_HR      = 5;

  // Encode a value below 1000 as three packed BCD digits.
  function automatic logic [11:0] to_bcd3(input int unsigned v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Packed-BCD modulo counter (0..MAX_VAL) with clear, step up and step down.
module bcd_mod_counter
  import clock_counter_pkg::*;
#(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MAX_VAL = 59
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   value,
  output logic                  carry_c
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [W-1:0] MAX_BCD = W'(to_bcd3(MAX_VAL));

  logic [W-1:0] value_d;

  // Add one with decimal digit carry.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Subtract one with decimal digit borrow.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Next value: clear wins, then increment, then decrement; wrap within range.
  always_comb begin
    value_d = value;
    if (clear) begin
      value_d = '0;
    end else if (inc) begin
      value_d = (value == MAX_BCD) ? '0 : bcd_inc(value);
    end else if (dec) begin
      value_d = (value == '0) ? MAX_BCD : bcd_dec(value);
    end
  end

  // Carry out on an increment that wraps MAX_VAL back to zero.
  assign carry_c = inc & ~clear & (value == MAX_BCD);

  // Value register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else begin
      value <= value_d;
    end
  end

endmodule

// File: rtl/clock_counter.sv
// 24-hour BCD clock: ms prescaler, carry chain and pushbutton field adjust.
module clock_counter
  import clock_counter_pkg::*;
#(
  parameter int unsigned TICKS_PER_MS = 100000
) (
  input  logic             clk_in,
  input  logic             resetn,
  input  logic             Button,
  input  logic [SET_W-1:0] set,
  output logic [11:0]      milli_o,
  output logic [7:0]       Seconds_o,
  output logic [7:0]       Minutes_o,
  output logic [7:0]       Hours_o
);

  localparam int unsigned PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);

  logic [PW-1:0] presc_q;
  logic          btn_meta_q, btn_sync_q, btn_prev_q;
  logic          adj_pulse, clear, pause, down, tick;
  logic          adj_sec, adj_min, adj_hr;
  logic          ms_carry, sec_carry, min_carry, hr_carry_unused;
  logic          sec_inc, sec_dec, min_inc, min_dec, hr_inc, hr_dec;
  logic          min_nat, hr_nat;

  assign clear = set[SET_CLR];
  assign pause = set[SET_PAUSE];
  assign down  = set[SET_DIR];
  assign tick  = ~clear & ~pause & (presc_q == PRESC_LAST);

  // Two-flop Button synchronizer plus previous-level register for edge detect.
  always_ff @(posedge clk_in or posedge resetn) begin
    if (resetn) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      btn_meta_q <= Button;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
    end
  end

  assign adj_pulse = btn_sync_q & ~btn_prev_q;
  assign adj_sec   = adj_pulse & set[SET_SEC];
  assign adj_min   = adj_pulse & set[SET_MIN];
  assign adj_hr    = adj_pulse & set[SET_HR];

  // Millisecond prescaler: cleared by clear, frozen by pause.
  always_ff @(posedge clk_in or posedge resetn) begin
    if (resetn) begin
      presc_q <= '0;
    end else if (clear) begin
      presc_q <= '0;
    end else if (!pause) begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
    end
  end

  // An adjust on a field replaces its natural carry-in and suppresses its carry-out.
  assign sec_inc = adj_sec ? ~down : ms_carry;
  assign sec_dec = adj_sec & down;
  assign min_nat = sec_carry & ~adj_sec;
  assign min_inc = adj_min ? ~down : min_nat;
  assign min_dec = adj_min & down;
  assign hr_nat  = min_carry & ~adj_min;
  assign hr_inc  = adj_hr ? ~down : hr_nat;
  assign hr_dec  = adj_hr & down;

  bcd_mod_counter #(.DIGITS(MS_DIGITS), .MAX_VAL(MS_MAX)) u_ms (
    .clk(clk_in), .rst(resetn), .inc(tick), .dec(1'b0), .clear(clear),
    .value(milli_o), .carry_c(ms_carry)
  );

  bcd_mod_counter #(.DIGITS(TIME_DIGITS), .MAX_VAL(SEC_MAX)) u_sec (
    .clk(clk_in), .rst(resetn), .inc(sec_inc), .dec(sec_dec), .clear(clear),
    .value(Seconds_o), .carry_c(sec_carry)
  );

  bcd_mod_counter #(.DIGITS(TIME_DIGITS), .MAX_VAL(MIN_MAX)) u_min (
    .clk(clk_in), .rst(resetn), .inc(min_inc), .dec(min_dec), .clear(clear),
    .value(Minutes_o), .carry_c(min_carry)
  );

  bcd_mod_counter #(.DIGITS(TIME_DIGITS), .MAX_VAL(HR_MAX)) u_hr (
    .clk(clk_in), .rst(resetn), .inc(hr_inc), .dec(hr_dec), .clear(clear),
    .value(Hours_o), .carry_c(hr_carry_unused)
  );

endmodule

// File: tb/tb_clock_counter.sv
// Bench for clock_counter: integer time model feeds a per-cycle scoreboard.
module tb_clock_counter;

  localparam int T = 2;

  logic        clk_in = 1'b0;
  logic        resetn;
  logic        Button;
  logic [5:0]  set;
  logic [11:0] milli_o;
  logic [7:0]  Seconds_o, Minutes_o, Hours_o;

  int checks = 0;
  int errors = 0;

  typedef struct {int ms; int s; int m; int h;} exp_t;
  exp_t exp_q[$];

  // Reference time state kept as plain integers.
  int m_ms, m_s, m_m, m_h, m_pre;
  bit b_hist0, b_hist1, b_hist2;

  clock_counter #(.TICKS_PER_MS(T)) dut (
    .clk_in(clk_in), .resetn(resetn), .Button(Button), .set(set),
    .milli_o(milli_o), .Seconds_o(Seconds_o), .Minutes_o(Minutes_o), .Hours_o(Hours_o)
  );

  always #5 clk_in = ~clk_in;

  function automatic int bcd2int(input logic [11:0] v, input int digits);
    int r;
    logic [3:0] d;
    r = 0;
    for (int i = digits - 1; i >= 0; i--) begin
      d = v[4*i +: 4];
      if (d > 4'd9) return -1;
      r = r * 10 + int'(d);
    end
    return r;
  endfunction

  function automatic int step(input int v, input int modulus, input bit dn);
    return dn ? (v + modulus - 1) % modulus : (v + 1) % modulus;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_time(input string tag, input int ms, input int s, input int m, input int h);
    check({tag, "_ms"},  bcd2int(milli_o, 3), ms);
    check({tag, "_sec"}, bcd2int({4'd0, Seconds_o}, 2), s);
    check({tag, "_min"}, bcd2int({4'd0, Minutes_o}, 2), m);
    check({tag, "_hr"},  bcd2int({4'd0, Hours_o}, 2), h);
  endtask

  // Reference model: advance the integer clock one cycle and queue the expected result.
  always @(posedge clk_in) begin
    bit pulse, tick, cs, cm, ch;
    if (resetn) begin
      m_ms = 0; m_s = 0; m_m = 0; m_h = 0; m_pre = 0;
      b_hist0 = 0; b_hist1 = 0; b_hist2 = 0;
    end else begin
      pulse = b_hist1 && !b_hist2;
      b_hist2 = b_hist1; b_hist1 = b_hist0; b_hist0 = Button;
      if (set[2]) begin
        m_ms = 0; m_s = 0; m_m = 0; m_h = 0; m_pre = 0;
      end else begin
        tick = 0;
        if (!set[1]) begin
          if (m_pre == T - 1) begin tick = 1; m_pre = 0; end
          else m_pre = m_pre + 1;
        end
        cs = tick && (m_ms == 999);
        if (tick) m_ms = (m_ms + 1) % 1000;
        cm = 0;
        if (pulse && set[3]) m_s = step(m_s, 60, set[0]);
        else if (cs) begin cm = (m_s == 59); m_s = (m_s + 1) % 60; end
        ch = 0;
        if (pulse && set[4]) m_m = step(m_m, 60, set[0]);
        else if (cm) begin ch = (m_m == 59); m_m = (m_m + 1) % 60; end
        if (pulse && set[5]) m_h = step(m_h, 24, set[0]);
        else if (ch) m_h = (m_h + 1) % 24;
      end
    end
    exp_q.push_back('{m_ms, m_s, m_m, m_h});
  end

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk_in) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check_time("sb", e.ms, e.s, e.m, e.h);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic press(input int hold);
    Button = 1'b1;
    cycles(hold);
    Button = 1'b0;
    cycles(4);
  endtask

  initial begin
    resetn = 1'b1;
    Button = 1'b0;
    set    = 6'b000010;
    cycles(3);
    check_time("reset_state", 0, 0, 0, 0);
    resetn = 1'b0;
    cycles(2);

    // Preload 23:59:59 while paused; hours decrement from 00 wraps to 23.
    set = 6'b100011; press(4);
    check_time("hr_dec_wrap", 0, 0, 0, 23);
    set = 6'b010011; press(4);
    set = 6'b001011; press(4);
    check_time("preload", 0, 59, 59, 23);

    // 1000 ms ticks roll the whole clock over to midnight.
    set = 6'b000000;
    cycles(1000 * T);
    check_time("rollover", 0, 0, 0, 0);

    // Single minute step with a long-held button.
    set = 6'b010000; press(12);
    check("min_adj_min", bcd2int({4'd0, Minutes_o}, 2), 1);
    check("min_adj_sec", bcd2int({4'd0, Seconds_o}, 2), 0);
    check("min_adj_hr",  bcd2int({4'd0, Hours_o}, 2), 0);

    // Seconds decrement wrap 00 -> 59.
    set = 6'b001001; press(4);
    check("sec_dec_wrap", bcd2int({4'd0, Seconds_o}, 2), 59);

    // Pause for 50+ ticks, then adjust with no field selected.
    set = 6'b000010; cycles(120);
    set = 6'b000001; press(4);

    // Clear zeroes everything on the next edge and overrides adjust.
    set = 6'b000100; cycles(1);
    check_time("clear", 0, 0, 0, 0);
    set = 6'b111100; press(4);
    check_time("clear_over_adj", 0, 0, 0, 0);

    // Collision: seconds adjust lands on the same edge as the ms 999 -> 000 carry.
    set = 6'b001010;
    repeat (10) press(4);
    check("coll_pre_sec", bcd2int({4'd0, Seconds_o}, 2), 10);
    set = 6'b001000;
    cycles(1000 * T - 3);
    Button = 1'b1;
    cycles(3);
    check("coll_sec", bcd2int({4'd0, Seconds_o}, 2), 11);
    check("coll_ms",  bcd2int(milli_o, 3), 0);
    Button = 1'b0;
    cycles(4);

    // Randomized control and button activity.
    for (int i = 0; i < 300; i++) begin
      set = 6'($urandom);
      if ($urandom_range(15) != 0) set[2] = 1'b0;
      if ($urandom_range(3) != 0)  set[1] = 1'b0;
      Button = 1'($urandom);
      cycles($urandom_range(1, 12));
    end
    Button = 1'b0;
    set = 6'b000000;
    cycles(37);

    // Asynchronous reset mid-run: outputs clear before any clock edge.
    #2 resetn = 1'b1;
    #1 check_time("async_reset", 0, 0, 0, 0);
    cycles(2);
    resetn = 1'b0;
    cycles(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
